// File: rtl/sa_phase_sequencer.sv
// Phase sequencer for the NxN systolic array: weight load, skewed activation feed
// and output drain for each start request, then a single-cycle done pulse.
module sa_phase_sequencer #(
    parameter int N  = 64,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          skip_load,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [2:0]    phase,
    output logic [CW-1:0] cycle_cnt,
    output logic          w_load_en,
    output logic [CW-1:0] w_addr,
    output logic          a_feed_en,
    output logic [CW-1:0] a_addr,
    output logic          acc_clr,
    output logic          out_valid,
    output logic [CW-1:0] out_row
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_DRN  = CW'(2 * N - 1);

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;

    always_comb begin
        nstate = state;
        ncnt   = cnt + CW'(1);
        case (state)
            IDLE: begin
                ncnt = '0;
                if (start) nstate = skip_load ? FEED : LOAD;
            end
            LOAD:  if (cnt == CNT_LAST) begin nstate = FEED;  ncnt = '0; end
            FEED:  if (cnt == CNT_LAST) begin nstate = DRAIN; ncnt = '0; end
            DRAIN: if (cnt == CNT_DRN)  begin nstate = DONE;  ncnt = '0; end
            DONE: begin
                nstate = IDLE;
                ncnt   = '0;
            end
            default: begin
                nstate = IDLE;
                ncnt   = '0;
            end
        endcase
        // abort outranks start and every phase transition
        if (abort) begin
            nstate = IDLE;
            ncnt   = '0;
        end
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase     <= 3'd0;
            cycle_cnt <= '0;
            w_load_en <= 1'b0;
            w_addr    <= '0;
            a_feed_en <= 1'b0;
            a_addr    <= '0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            busy      <= (nstate != IDLE);
            done      <= (nstate == DONE);
            phase     <= nstate;
            cycle_cnt <= ncnt;
            w_load_en <= (nstate == LOAD);
            w_addr    <= (nstate == LOAD) ? ncnt : '0;
            a_feed_en <= (nstate == FEED);
            a_addr    <= (nstate == FEED) ? ncnt : '0;
            acc_clr   <= (nstate == FEED) && (ncnt == '0);
            // rows emerge only in the second half of the drain, after the skew settles
            out_valid <= (nstate == DRAIN) && (ncnt >= CNT_N);
            out_row   <= ((nstate == DRAIN) && (ncnt >= CNT_N)) ? ncnt - CNT_N : '0;
        end
    end

endmodule
